// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch front end sitting directly upstream of the IF/ID register.
// Owns the fetch PC and issues word-aligned requests to instruction memory over
// a req/gnt/rvalid interface, with up to MAX_OUTSTANDING requests in flight.
// Returned instructions are tagged with their PC and queued in a BUF_DEPTH
// entry FIFO. The FIFO head is presented to IF/ID as {o_pc, o_inst}. A redirect
// from EX flushes the FIFO and discards every old-path response still in
// flight.
//
// Ports:
//   i_clk          clock
//   i_reset        asynchronous reset, active low
//   i_stall        IF/ID hold; head entry is not consumed this cycle
//   i_redirect     control-flow redirect from EX
//   i_redirect_pc  redirect target (bits [1:0] ignored)
//   o_imem_req     fetch request
//   o_imem_addr    word-aligned fetch address
//   i_imem_gnt     request accepted this cycle
//   i_imem_rvalid  in-order response valid
//   i_imem_rdata   response instruction
//   o_pc           PC of presented instruction (0 when empty)
//   o_inst         presented instruction (NOP 0x00000013 when empty)
//   o_valid        o_pc/o_inst hold a real instruction
//
// Build option:
//   FETCH_BYPASS_EN  when defined, a kept response arriving into an empty FIFO
//                    is presented combinationally in the same cycle, and is
//                    not written into the FIFO if IF/ID consumes it.
// ----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          BUF_DEPTH       = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_pc,
   output logic [31:0] o_inst,
   output logic        o_valid
);

   localparam logic [31:0] NOP = 32'h0000_0013;
   // one spare bit so outstanding + buffered never wraps
   localparam int CW = $clog2(BUF_DEPTH + 1) + 1;
   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding_cnt;
   logic [CW-1:0] discard_cnt;
   logic [CW-1:0] fifo_count;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [TW-1:0] tag_rd;
   logic [TW-1:0] tag_wr;
   logic [31:0]   fifo_pc   [BUF_DEPTH];
   logic [31:0]   fifo_inst [BUF_DEPTH];
   logic [31:0]   tag_q     [MAX_OUTSTANDING];

   logic          rsp_take;
   logic          rsp_keep;
   logic          fifo_empty;
   logic          bypass;
   logic          pop;
   logic          fifo_pop;
   logic          fifo_push;
   logic          credit_ok;
   logic          handshake;
   logic [CW-1:0] committed;
   logic [31:0]   tag_pc;
   logic [31:0]   redirect_target;

   function automatic logic [PW-1:0] fifo_next(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
      return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
   endfunction

   assign redirect_target = i_redirect_pc & 32'hFFFF_FFFC;
   assign tag_pc          = tag_q[tag_rd];

   // Responses arriving with nothing outstanding (memory coming out of reset
   // alongside us) are ignored entirely.
   assign rsp_take   = i_imem_rvalid && (outstanding_cnt != '0);
   assign rsp_keep   = rsp_take && (discard_cnt == '0) && !i_redirect;
   assign fifo_empty = (fifo_count == '0);

`ifdef FETCH_BYPASS_EN
   assign bypass = fifo_empty && rsp_keep;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      o_valid = 1'b0;
      o_pc    = '0;
      o_inst  = NOP;
      if (!fifo_empty) begin
         o_valid = 1'b1;
         o_pc    = fifo_pc[rd_ptr];
         o_inst  = fifo_inst[rd_ptr];
      end else if (bypass) begin
         o_valid = 1'b1;
         o_pc    = tag_pc;
         o_inst  = i_imem_rdata;
      end
   end

   assign pop       = o_valid && !i_stall && !i_redirect;
   assign fifo_pop  = pop && !fifo_empty;
   assign fifo_push = rsp_keep && !(bypass && pop);

   // A slot freed by this cycle's pop may be re-used by this cycle's request,
   // which is what sustains one instruction per cycle with BUF_DEPTH = 2.
   assign committed = outstanding_cnt + fifo_count - CW'(pop);
   assign credit_ok = (committed < CW'(BUF_DEPTH)) &&
                      (outstanding_cnt < CW'(MAX_OUTSTANDING));

   assign o_imem_req  = i_reset && credit_ok && !i_redirect;
   assign o_imem_addr = fetch_pc;
   assign handshake   = o_imem_req && i_imem_gnt;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         fetch_pc        <= RESET_PC;
         outstanding_cnt <= '0;
         discard_cnt     <= '0;
         fifo_count      <= '0;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         tag_rd          <= '0;
         tag_wr          <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            fifo_pc[i]   <= '0;
            fifo_inst[i] <= '0;
         end
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         // tags retire with every response, old-path or not
         if (rsp_take) begin
            tag_rd <= tag_next(tag_rd);
         end

         if (i_redirect) begin
            // everything still in flight belongs to the old path
            fetch_pc        <= redirect_target;
            outstanding_cnt <= outstanding_cnt - CW'(rsp_take);
            discard_cnt     <= outstanding_cnt - CW'(rsp_take);
            fifo_count      <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
         end else begin
            if (handshake) begin
               fetch_pc       <= fetch_pc + 32'd4;
               tag_q[tag_wr]  <= fetch_pc;
               tag_wr         <= tag_next(tag_wr);
            end
            outstanding_cnt <= outstanding_cnt + CW'(handshake) - CW'(rsp_take);
            if (rsp_take && (discard_cnt != '0)) begin
               discard_cnt <= discard_cnt - CW'(1);
            end
            if (fifo_push) begin
               fifo_pc[wr_ptr]   <= tag_pc;
               fifo_inst[wr_ptr] <= i_imem_rdata;
               wr_ptr            <= fifo_next(wr_ptr);
            end
            if (fifo_pop) begin
               rd_ptr <= fifo_next(rd_ptr);
            end
            fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//
// Randomized bench for fetch_stage. A memory model answers requests in order
// after a configurable latency. The reference model only knows the program
// order rule: after reset or a redirect to T, IF/ID must see T, T+4, T+8 ...
// each carrying the memory word at that PC, and nothing from an abandoned path.
// Expected entries are queued as requests are accepted; a separate monitor
// pops and compares whenever IF/ID consumes an instruction.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC        = 32'h0000_0000;
   localparam int          BUF_DEPTH       = 2;
   localparam int          MAX_OUTSTANDING = 2;
`ifdef FETCH_BYPASS_EN
   localparam int          EXP_LAT         = 1;
`else
   localparam int          EXP_LAT         = 2;
`endif

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_stall = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt = 1'b0;
   logic        i_imem_rvalid = 1'b0;
   logic [31:0] i_imem_rdata = '0;
   logic [31:0] o_pc;
   logic [31:0] o_inst;
   logic        o_valid;

   fetch_stage #(
      .RESET_PC        (RESET_PC),
      .BUF_DEPTH       (BUF_DEPTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_stall       (i_stall),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .o_pc          (o_pc),
      .o_inst        (o_inst),
      .o_valid       (o_valid)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   mreq_t       memq [$];
   exp_t        exp_q [$];
   int          cyc = 0;
   int          lat = 1;
   logic [31:0] model_pc = RESET_PC;
   int          since_rst = 0;
   int          first_valid = -1;
   bit          prev_req = 1'b0;
   bit          prev_gnt = 1'b0;
   logic [31:0] prev_addr = '0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit mem_due();
      return (memq.size() > 0) && (memq[0].due <= cyc);
   endfunction

   // one clock cycle: drive at negedge, sample settled outputs 1 unit later
   task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit gn);
      @(negedge i_clk);
      i_reset       = 1'b1;
      i_stall       = st;
      i_redirect    = rd;
      i_redirect_pc = rpc;
      i_imem_gnt    = gn;
      i_imem_rvalid = mem_due();
      i_imem_rdata  = i_imem_rvalid ? memfn(memq[0].addr) : $urandom;
      #1;
      if (prev_req && !prev_gnt && !rd) begin
         chk("req_hold", o_imem_req, 1);
         chk("addr_hold", o_imem_addr, prev_addr);
      end
      if (rd) chk("req_in_redirect", o_imem_req, 0);
      if (o_imem_req && gn) begin
         chk("req_addr", o_imem_addr, model_pc);
         exp_q.push_back('{model_pc, memfn(model_pc)});
         memq.push_back('{o_imem_addr, cyc + lat});
         model_pc = model_pc + 32'd4;
      end
      if (i_imem_rvalid) void'(memq.pop_front());
      if (rd) begin
         exp_q.delete();
         model_pc = {rpc[31:2], 2'b00};
      end
      chk("outstanding_limit", memq.size() <= MAX_OUTSTANDING, 1);
      if (o_valid && first_valid < 0) first_valid = since_rst;
      prev_req  = o_imem_req;
      prev_gnt  = gn;
      prev_addr = o_imem_addr;
      since_rst++;
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_reset       = 1'b0;
      i_stall       = 1'b0;
      i_redirect    = 1'b0;
      i_imem_gnt    = 1'b0;
      i_imem_rvalid = 1'b0;
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_inst", o_inst, 32'h0000_0013);
      chk("rst_pc", o_pc, 0);
      chk("rst_req", o_imem_req, 0);
      memq.delete();
      exp_q.delete();
      model_pc    = RESET_PC;
      prev_req    = 1'b0;
      since_rst   = 0;
      first_valid = -1;
      @(negedge i_clk);
   endtask

   // monitor: compares every consumed instruction against the scoreboard
   logic [31:0] last_pc = '0;
   logic [31:0] last_inst = '0;
   bit          last_hold = 1'b0;

   initial begin
      forever begin
         @(negedge i_clk);
         #2;
         if (!i_reset) begin
            last_hold = 1'b0;
         end else begin
            if (last_hold) begin
               chk("stall_valid", o_valid, 1);
               chk("stall_pc", o_pc, last_pc);
               chk("stall_inst", o_inst, last_inst);
            end
            if (!o_valid) begin
               chk("bubble_pc", o_pc, 0);
               chk("bubble_inst", o_inst, 32'h0000_0013);
            end
            if (o_valid && !i_stall && !i_redirect) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pop actual_pc=%h expected=none", o_pc);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("pop_pc", o_pc, e.pc);
                  chk("pop_inst", o_inst, e.inst);
               end
            end
            chk("credit", exp_q.size() <= BUF_DEPTH, 1);
            last_hold = o_valid && i_stall && !i_redirect;
            last_pc   = o_pc;
            last_inst = o_inst;
         end
      end
   end

   initial begin
      int  valid_cnt;
      bit  found;

      // streaming from reset, 1-cycle memory, gnt always high
      do_reset();
      lat = 1;
      valid_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         step(0, 0, 0, 1);
         if ((since_rst - 1) >= EXP_LAT && o_valid) valid_cnt++;
      end
      chk("first_valid_latency", first_valid, EXP_LAT);
      chk("throughput", valid_cnt, 25 - EXP_LAT);

      // stall for 4 cycles mid-stream, then resume
      for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

      // gnt low for 3 cycles: address must sit at 0x8
      do_reset();
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0);
         chk("gnt_low_req", o_imem_req, 1);
         chk("gnt_low_addr", o_imem_addr, 32'h0000_0008);
      end
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

      // redirect to 0x103 with a 2-cycle memory
      lat = 2;
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
      step(0, 1, 32'h0000_0103, 1);
      step(0, 0, 0, 1);
      chk("redir_addr", o_imem_addr, 32'h0000_0100);
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1);

      // redirect coinciding with stall and rvalid
      lat = 1;
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mem_due()) begin
            found = 1'b1;
            break;
         end
         step(0, 0, 0, 1);
      end
      chk("rvalid_found", found, 1);
      step(1, 1, 32'h0000_0200, 1);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

      // reset mid-stream with a request outstanding
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
      chk("mid_outstanding", memq.size() > 0, 1);
      do_reset();
      step(0, 0, 0, 1);
      chk("post_rst_addr", o_imem_addr, RESET_PC);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
      chk("post_rst_latency", first_valid, EXP_LAT);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         lat = 1 + $urandom_range(2);
         step(($urandom_range(3) == 0), ($urandom_range(19) == 0), $urandom,
              ($urandom_range(9) < 7));
      end

      // drain
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage forwarding pipeline. Sits directly upstream of the IF/ID register.
- Owns the fetch PC. Issues requests to instruction memory over a req/gnt/rvalid interface, with up to MAX_OUTSTANDING requests in flight.
- Buffers returned instructions in a small FIFO and presents one {pc, inst} per cycle to IF/ID.
- Handles redirects (branch/jump from EX) by flushing the buffer and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- BUF_DEPTH, 2, instruction FIFO entries; also the credit limit on (outstanding + buffered).
- MAX_OUTSTANDING, 2, maximum granted-but-unreturned requests; must be <= BUF_DEPTH.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-low reset
- i_stall  in  1  IF/ID hold from hazard unit; head entry not consumed this cycle
- i_redirect  in  1  control-flow redirect from EX
- i_redirect_pc  in  32  redirect target; bits [1:0] forced to 0
- o_imem_req  out  1  fetch request
- o_imem_addr  out  32  word-aligned fetch address
- i_imem_gnt  in  1  request accepted this cycle
- i_imem_rvalid  in  1  in-order response valid
- i_imem_rdata  in  32  response instruction
- o_pc  out  32  PC of presented instruction
- o_inst  out  32  presented instruction
- o_valid  out  1  o_pc/o_inst hold a real instruction

Behaviour:
- Reset is i_reset, asynchronous, active-low, clock i_clk.
- State cleared on reset:
  - fetch_pc = RESET_PC.
  - outstanding_cnt, discard_cnt, FIFO count, FIFO pointers, and PC-tag queue = 0.
  - o_valid = 0, o_imem_req = 0, o_pc = 0, o_inst = 32'h0000_0013 (NOP).
- Reset mid-operation drops everything in flight. The memory is reset in lockstep; a post-reset rvalid with outstanding_cnt = 0 is ignored.
- Pop:
  - pop = o_valid && !i_stall && !i_redirect.
  - The IF/ID register captures on the same edge.
- Credit check:
  - credit_ok = (outstanding_cnt + fifo_count - pop) < BUF_DEPTH && outstanding_cnt < MAX_OUTSTANDING.
  - o_imem_req = credit_ok && !i_redirect.
  - o_imem_addr = fetch_pc.
- Request protocol:
  - While req is high and gnt is low, the address holds stable.
  - req may drop only because of i_redirect or loss of credit.
- On req && gnt:
  - fetch_pc += 4, wrapping mod 2^32.
  - outstanding_cnt increments.
  - fetch_pc is pushed into the PC-tag queue (depth MAX_OUTSTANDING).
- On rvalid:
  - outstanding_cnt decrements and the PC-tag queue pops.
  - If discard_cnt > 0: discard_cnt decrements and the data is dropped.
  - Otherwise {tag_pc, rdata} is pushed into the FIFO.
- Credit guarantees the FIFO never overflows. A simultaneous push and pop leaves the count unchanged.
- Outputs:
  - o_valid = fifo_count != 0.
  - o_pc/o_inst come from the FIFO head.
  - When the FIFO is empty: o_pc = 0 and o_inst = 32'h0000_0013, so IF/ID captures a bubble.
- Redirect (priority over stall, pop, and request):
  - The FIFO is cleared the same edge.
  - fetch_pc <= {i_redirect_pc[31:2], 2'b00}.
  - discard_cnt <= outstanding_cnt - i_imem_rvalid. This covers every in-flight old-path response; an rvalid in the redirect cycle is itself dropped.
  - outstanding_cnt <= outstanding_cnt - i_imem_rvalid.
  - No request is issued in the redirect cycle. The first new-path request comes the next cycle if credit allows.
  - Back-to-back redirects: the last one wins, and discard_cnt recomputes from the current outstanding_cnt.
- Latency:
  - With a 1-cycle memory (rvalid the cycle after gnt), an instruction appears on o_valid 2 cycles after its request.
  - Sustained throughput is 1 instruction/cycle when i_stall = 0.
- i_stall:
  - Holds the head entry and o_pc/o_inst stable.
  - Fetching continues until credit is exhausted.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When the FIFO is empty and a non-discarded rvalid arrives, o_valid = 1 and o_pc/o_inst = {tag_pc, rdata} combinationally in the same cycle.
  - If popped that cycle, the entry is not written into the FIFO.
  - 1-cycle memory latency request-to-IF/ID becomes 1 cycle.
- FETCH_BYPASS_EN undefined: all responses pass through the FIFO (behaviour above).

Test Plan:
- Reset release, 1-cycle memory, gnt always high, no stall -> addresses 0x0, 0x4, 0x8, ... one per cycle; o_pc sequence 0x0, 0x4, 0x8 with o_valid continuously high from cycle 2.
- i_stall high for 4 cycles while streaming -> o_pc/o_inst frozen; at most 2 requests outstanding+buffered; stream resumes in order with no lost or duplicated PCs.
- gnt held low for 3 cycles with req high -> o_imem_addr stable at 0x8 throughout; fetch_pc advances only on gnt.
- Redirect to 0x103 with 2 responses in flight (2-cycle memory) -> FIFO empties; 2 responses dropped; next request addr 0x100; first o_valid instruction has o_pc = 0x100.
- Redirect in the same cycle as a stall and an rvalid -> redirect wins; the rvalid is dropped; no instruction from the old path is ever presented.
- Assert i_reset mid-stream with 1 outstanding -> o_valid = 0 and o_inst = 0x00000013 immediately; first request after release at RESET_PC.
